uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Sequencing controller that shares the single-byte UART transmitter between `N_REQ` requesters. It accepts per-requester byte requests and chooses one by round-robin. It then issues the transmitter's one-cycle `trigger` with the byte on `q_in` and holds off further launches until the transmitter's `busy` has risen and fallen. It sits between the byte producers (console, status reporter, debug dump) and the transmitter instance; `clk_en` (baud tick) is generated elsewhere and is not touched here.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width; must match transmitter `q_in`.
- `TIMEOUT_CYC`, default 4096: watchdog limit in `clk` cycles; used only with `UART_TX_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; one clock domain, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester byte request; level, held until `ack`.
- `req_data`  in  N_REQ*DATA_W  byte of requester i at `[i*DATA_W +: DATA_W]`; stable while `req[i]`=1.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: requester's byte captured and launched.
- `tx_trigger`  out  1  one-cycle launch pulse to transmitter `trigger`.
- `tx_data`  out  DATA_W  to transmitter `q_in`; registered, stable from launch until the transmission ends.
- `tx_busy`  in  1  from transmitter `busy`.
- `owner`  out  clog2(N_REQ)  index of the last granted requester.
- `tx_timeout`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE:** if any `req` bit is set, pick the winner by round-robin, register `req_data` of the winner into `tx_data`, update `owner`, and go to LAUNCH. Otherwise stay in IDLE.
  - Search order starts at `owner+1` and wraps modulo N_REQ.
  - The pointer resets to N_REQ-1, so requester 0 wins first after reset.
- **LAUNCH:** assert `tx_trigger`=1 and `ack[owner]`=1 for this single cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** stay until `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** stay until `tx_busy`=0, then go to IDLE.
- Requester withdrawing `req` before `ack`: nothing is granted and no byte is lost.
- Requester keeping `req` high the cycle after `ack`: this is treated as a new byte and competes in the next IDLE arbitration. Round-robin prevents it from starving others.
- `tx_busy` already high on entry to IDLE (foreign or stale transfer): arbitration is held off; IDLE grants only while `tx_busy`=0.
- `req` bits for indices ≥ N_REQ do not exist; `req_data` is sampled only for the winner.

## Timing
- **Reset values:** state IDLE, `ack`=0, `tx_trigger`=0, `tx_data`=0, `owner`=N_REQ-1, `tx_timeout`=0, watchdog counter 0.
- **Reset mid-operation:** all outputs go to reset values immediately (asynchronously). The in-flight transmission is abandoned by the arbiter and no new `ack` is issued for it.
- **Latency:** `req` sampled high in IDLE at edge k → `tx_trigger`/`ack` high during cycle k+1.
- `tx_busy` may rise any number of cycles after the trigger (≥1).
- **Back-to-back:** `tx_busy` falls at edge m → IDLE at m; next trigger at m+2 at the earliest.
- `tx_data` changes only on the IDLE→LAUNCH transition.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE and clears on every state change.
  - On reaching TIMEOUT_CYC the FSM returns to IDLE and pulses `tx_timeout` for one cycle.
  - The `owner` pointer still advances.
- Not defined:
  - No counter is built and `tx_timeout` is tied 0.
  - The FSM waits indefinitely on `tx_busy`.

## Structure
- Shared package `uart_pkg`: FSM state encoding (localparams for IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE) and the default `DATA_W`=8, shared with the transmitter.
- One sub-module, `rr_arbiter`:
  - Purely combinational.
  - Inputs: `req` and the `owner` pointer.
  - Outputs: one-hot grant, its index, and a valid flag.
- The FSM, data register and watchdog live in `uart_tx_arbiter`.

## Test plan
- **Single request:** after reset, `req`=0001 with byte 8'hF0 → `tx_trigger` and `ack`=0001 one cycle later; `tx_data`=F0; no second trigger until `tx_busy` has risen and fallen.
- **All four requesting continuously:** bytes 8'h00, 8'h11, 8'h22, 8'h33 → grant order 0,1,2,3,0.
- **Back-to-back from one requester:** `req[2]` held high across `ack`, others idle → two launches; the second trigger is exactly 2 cycles after `tx_busy` falls.
- **Withdrawal:** `req[1]` pulses one cycle while the FSM is in WAIT_DONE → no `ack[1]`, no trigger.
- **Reset mid-operation:** `rst_n` low during WAIT_DONE → `tx_trigger`/`ack`=0 and `owner`=N_REQ-1 immediately; after release, requester 0 wins first.
- **Watchdog, macro defined, TIMEOUT_CYC=16:** `tx_busy` never rises → `tx_timeout` pulses 16 cycles after entering WAIT_BUSY, FSM returns to IDLE; without the macro, FSM stays in WAIT_BUSY and `tx_timeout` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART definitions: byte width and arbiter FSM encoding |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE      = ST_IDLE,
        ARB_LAUNCH    = ST_LAUNCH,
        ARB_WAIT_BUSY = ST_WAIT_BUSY,
        ARB_WAIT_DONE = ST_WAIT_DONE
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin pick, searching from owner+1       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] owner,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_cand      = '0;
        // Offset N_REQ wraps back to the owner itself, so it is checked last.
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = IDX_W'((int'(owner) + off) % N_REQ);
            if (!grant_valid && req[w_cand]) begin
                grant_valid   = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin sharing of one UART transmitter; optional busy   |
// |               watchdog enabled by define UART_TX_ARB_TIMEOUT_EN            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 4096,
    localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    tx_trigger,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [IDX_W-1:0]        owner,
    output logic                    tx_timeout
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 2");
    end

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [DATA_W-1:0] r_tx_data;
    logic [IDX_W-1:0]  r_owner;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_grant_valid;
    logic              w_accept;
    logic              w_wd_expired;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .owner       (r_owner),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_owner   <= IDX_W'(N_REQ - 1);
            r_tx_data <= '0;
            r_grant   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner   <= w_grant_idx;
                r_tx_data <= req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
                r_grant   <= w_grant;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        tx_trigger   = 1'b0;
        ack          = '0;
        case (r_state)
            // A busy transmitter here belongs to someone else; do not launch over it.
            ARB_IDLE: begin
                if (!tx_busy && w_grant_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                tx_trigger   = 1'b1;
                ack          = r_grant;
                w_state_next = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy)
                    w_state_next = ARB_WAIT_DONE;
                else if (w_wd_expired)
                    w_state_next = ARB_IDLE;
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy || w_wd_expired)
                    w_state_next = ARB_IDLE;
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_tx_timeout;
    logic            w_waiting;
    logic            w_timeout;

    assign w_waiting    = (r_state == ARB_WAIT_BUSY) || (r_state == ARB_WAIT_DONE);
    assign w_wd_expired = w_waiting && (r_wd_cnt == c_wd_last);
    // Only flag a timeout when the normal busy handshake is not completing this cycle.
    assign w_timeout    = w_wd_expired &&
                          (((r_state == ARB_WAIT_BUSY) && !tx_busy) ||
                           ((r_state == ARB_WAIT_DONE) &&  tx_busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt     <= '0;
            r_tx_timeout <= 1'b0;
        end else begin
            r_tx_timeout <= w_timeout;
            if (w_state_next != r_state)
                r_wd_cnt <= '0;
            else if (w_waiting)
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign tx_timeout = r_tx_timeout;
`else
    assign w_wd_expired = 1'b0;
    assign tx_timeout   = 1'b0;
`endif

    assign tx_data = r_tx_data;
    assign owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                           |
// | Description : Scoreboard bench for uart_tx_arbiter (directed vectors)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int TO_CYC = 16;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_REQ-1:0]  req = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic              tx_busy = 1'b0;
    logic [N_REQ-1:0]  ack;
    logic              tx_trigger;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        owner;
    logic              tx_timeout;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_trig = 0;
    int   trig_base;

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_trigger (tx_trigger),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .owner      (owner),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every launch must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tx_trigger === 1'b1) begin
                n_trig++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_launch: ack=%b tx_data=%h, expected no launch", ack, tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_ack", 32'(ack), 32'(4'b0001 << mon_e.idx));
                    check("sb_owner", 32'(owner), 32'(mon_e.idx));
                    check("sb_tx_data", 32'(tx_data), 32'(mon_e.data));
                end
            end else if (ack !== '0) begin
                checks++;
                errors++;
                $display("FAIL sb_ack_without_trigger: ack=%b expected 0000", ack);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trigger(input string name);
        int n = 0;
        @(negedge clk);
        while (tx_trigger !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (tx_trigger !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: tx_trigger=%b after 40 cycles, expected 1", name, tx_trigger);
        end
    endtask

    task automatic busy_cycle(input int rise, input int len);
        repeat (rise) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_trigger", 32'(tx_trigger), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_owner", 32'(owner), 3);
        check("rst_timeout", 32'(tx_timeout), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single request: trigger one cycle later, then held off until busy rises and falls
        req_data[7:0] = 8'hF0;
        req = 4'b0001;
        push_exp(0, 8'hF0);
        tick();
        check("t1_latency_trigger", 32'(tx_trigger), 1);
        check("t1_latency_ack", 32'(ack), 32'(4'b0001));
        req = 4'b0000;
        tick();
        repeat (3) begin
            tick();
            check("t1_hold_wait_busy", 32'(tx_trigger), 0);
        end
        tx_busy = 1'b1;
        repeat (4) tick();
        check("t1_tx_data_stable", 32'(tx_data), 32'(8'hF0));
        tx_busy = 1'b0;
        repeat (4) tick();
        check("t1_trigger_count", 32'(n_trig), 1);

        // All four requesting continuously: order 0,1,2,3,0 after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        trig_base = n_trig;
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        req = 4'b1111;
        push_exp(0, 8'h00);
        push_exp(1, 8'h11);
        push_exp(2, 8'h22);
        push_exp(3, 8'h33);
        push_exp(0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            wait_trigger("t2_wait_trigger");
            if (i == 4) req = 4'b0000;
            busy_cycle(2, 3);
        end
        repeat (4) tick();
        check("t2_trigger_count", 32'(n_trig - trig_base), 5);

        // Back-to-back from requester 2: second trigger 2 cycles after busy falls
        trig_base = n_trig;
        req_data[23:16] = 8'h2C;
        req = 4'b0100;
        push_exp(2, 8'h2C);
        push_exp(2, 8'h2C);
        wait_trigger("t3_first_trigger");
        busy_cycle(1, 3);
        @(posedge clk);
        @(negedge clk);
        check("t3_gap_after_fall", 32'(tx_trigger), 0);
        @(posedge clk);
        @(negedge clk);
        check("t3_b2b_trigger", 32'(tx_trigger), 1);
        req = 4'b0000;
        busy_cycle(1, 2);
        repeat (4) tick();
        check("t3_trigger_count", 32'(n_trig - trig_base), 2);

        // Withdrawal: req[1] pulses during WAIT_DONE and is never granted
        trig_base = n_trig;
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        push_exp(0, 8'hA5);
        wait_trigger("t4_trigger");
        req = 4'b0000;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (2) tick();
        req_data[15:8] = 8'h99;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        repeat (2) tick();
        tx_busy = 1'b0;
        repeat (5) tick();
        check("t4_no_grant_on_withdraw", 32'(n_trig - trig_base), 1);

        // Reset mid-operation during WAIT_DONE
        req_data[15:8] = 8'h5A;
        req = 4'b0010;
        push_exp(1, 8'h5A);
        wait_trigger("t5_trigger");
        req = 4'b0000;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_owner", 32'(owner), 3);
        check("t5_async_trigger", 32'(tx_trigger), 0);
        check("t5_async_ack", 32'(ack), 0);
        check("t5_async_tx_data", 32'(tx_data), 0);
        tx_busy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        req_data = {8'h34, 8'h23, 8'h12, 8'h01};
        req = 4'b1111;
        push_exp(0, 8'h01);
        wait_trigger("t5_first_after_reset");
        req = 4'b0000;
        busy_cycle(1, 2);
        repeat (3) tick();

        // Watchdog: busy never rises after a launch
        req_data[31:24] = 8'hC3;
        req = 4'b1000;
        push_exp(3, 8'hC3);
        wait_trigger("t6_trigger");
        req = 4'b0000;
        repeat (16) begin
            @(posedge clk);
            @(negedge clk);
            check("t6_no_early_timeout", 32'(tx_timeout), 0);
        end
        @(posedge clk);
        @(negedge clk);
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("t6_timeout_pulse", 32'(tx_timeout), 1);
        push_exp(0, 8'h77);
`else
        check("t6_timeout_tied_low", 32'(tx_timeout), 0);
`endif
        req_data[7:0] = 8'h77;
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        check("t6_timeout_one_cycle", 32'(tx_timeout), 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("t6_relaunch_after_timeout", 32'(tx_trigger), 1);
        req = 4'b0000;
        busy_cycle(1, 2);
        repeat (3) tick();
`else
        check("t6_stuck_in_wait_busy", 32'(tx_trigger), 0);
        repeat (3) tick();
        check("t6_still_stuck", 32'(tx_trigger), 0);
        req = 4'b0000;
`endif

        check("sb_queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
